// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants for the 640x480@60 raster generator.
//   - VGA_* : default visible/porch/sync widths, derived totals and the
//             first/last sync positions for the default mode.
//   - CNT_W : raster counter width (10 bits covers 0..799 and 0..524).
//   - cnt_t : raster counter type.
//   - in_span : inclusive range test used by the sync decoders.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Horizontal timing in pixels.
  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;

  // Vertical timing in lines.
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync pulses sit right after the front porch.
  localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
  localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
  localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  // 100 MHz / 4 = 25 MHz pixel rate; one move strobe per frame.
  localparam int unsigned VGA_PIX_DIV     = 4;
  localparam int unsigned VGA_MOVE_FRAMES = 1;

  function automatic logic in_span(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pix_clk_div.sv
// pix_clk_div
// Modulo-PIX_DIV counter producing a registered one-clock pixel strobe.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   pixpulse_o : high for one clock every PIX_DIV clocks, in the clock where
//                the internal counter holds PIX_DIV-1
module pix_clk_div #(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic pixpulse_o
);

  localparam int unsigned DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_q;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  // The strobe is decoded from the next count so it is high exactly while
  // the counter itself sits at PIX_DIV-1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      pix_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pix_q <= (div_d == DIV_LAST);
    end
  end

  assign pixpulse_o = pix_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Pixel-timing front end: pixel strobe, raster counters, sync, blanking and
// the per-frame move strobe for the game display.
//   clk         : 100 MHz system clock
//   rst         : asynchronous active-low reset
//   move_en     : low suppresses move (pause)
//   pixpulse    : one-clock pixel strobe every PIX_DIV clocks
//   hcount      : pixel column 0..H_TOTAL-1
//   vcount      : line 0..V_TOTAL-1
//   hsync/vsync : active-low sync pulses
//   blank       : high outside the visible area
//   frame_start : high for the pixel period at (0,0) (not on the first frame)
//   move        : high for the pixel period at (0,V_VISIBLE) on strobe frames
// Build option: define VGA_MOVE_DIV_EN to add an 8-bit frame counter so that
// move fires only once every MOVE_FRAMES enabled frames.
//
// Consumer handshake: pixpulse is the sole qualifier. All other outputs are
// stable for the whole pixel period (PIX_DIV clocks) and consumers sample them
// in the clock where pixpulse is high; there is no back-pressure.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = VGA_H_VISIBLE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_VISIBLE   = VGA_V_VISIBLE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned PIX_DIV     = VGA_PIX_DIV,
  parameter int unsigned MOVE_FRAMES = VGA_MOVE_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move_en,
  output logic             pixpulse,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             blank,
  output logic             frame_start,
  output logic             move
);

  if (PIX_DIV < 2 || MOVE_FRAMES < 1 || MOVE_FRAMES > 255) begin : g_bad_param
    $error("vga_sync_gen: PIX_DIV must be >= 2 and MOVE_FRAMES in 1..255");
  end

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(H_VISIBLE);
  localparam cnt_t V_ACT    = cnt_t'(V_VISIBLE);
  localparam cnt_t HS_FIRST = cnt_t'(H_VISIBLE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_VISIBLE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic pix_w;

  pix_clk_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_clk_div (
    .clk_i      (clk),
    .rst_ni     (rst),
    .pixpulse_o (pix_w)
  );

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;
  logic hsync_q, vsync_q, blank_q, frame_start_q;
  logic move_hit_q, move_en_q;
  logic move_entry;
  logic hit_d;

  // Raster advance: one step per pixel strobe, wrapping at the totals.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_w) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
      end else begin
        h_d = h_q + cnt_t'(1);
      end
    end
  end

  // The step that lands on (0,V_VISIBLE): first line of vertical blanking.
  assign move_entry = pix_w && (h_d == '0) && (v_d == V_ACT);

`ifdef VGA_MOVE_DIV_EN
  localparam logic [7:0] FC_LAST = 8'(MOVE_FRAMES - 1);

  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts enabled strobe entries only, so a paused frame delays the next
  // strobe instead of consuming a slot.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (move_entry && move_en) begin
      frame_cnt_d = (frame_cnt_q == FC_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hit_d = move_entry && (frame_cnt_q == 8'd0);
`else
  assign hit_d = move_entry;
`endif

  // Decodes use the next counter values and update only on a raster step,
  // so they line up with the counters and the reset frame never reports a
  // frame_start at (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      move_hit_q    <= 1'b0;
      move_en_q     <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (pix_w) begin
        hsync_q       <= !in_span(h_d, HS_FIRST, HS_LAST);
        vsync_q       <= !in_span(v_d, VS_FIRST, VS_LAST);
        blank_q       <= (h_d >= H_ACT) || (v_d >= V_ACT);
        frame_start_q <= (h_d == '0) && (v_d == '0);
        move_hit_q    <= hit_d;
      end
      // Gate is latched once per frame, so toggling move_en during the
      // strobe cannot chop it.
      if (move_entry) begin
        move_en_q <= move_en;
      end
    end
  end

  assign pixpulse    = pix_w;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign move        = move_hit_q & move_en_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Bench for vga_sync_gen. A reduced-timing instance (dut) is run for many
// frames against a per-pixel reference model; a default-timing instance
// (dut_d) is checked over its first line and a bit. Expected per-pixel
// outputs are queued when the model enters a pixel; a monitor compares them
// on every falling edge and pops on the pixel strobe.
module tb_vga_sync_gen;

  localparam int D   = 3;
  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 2;
  localparam int VV  = 6;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int MF  = 3;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int FRAME_CLKS = HT * VT * D;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic move_en = 1'b0;
  logic move_en_d = 1'b0;

  always #5 clk = ~clk;

  logic       pixpulse, hsync, vsync, blank, frame_start, move;
  logic [9:0] hcount, vcount;
  logic       pixpulse_d, hsync_d, vsync_d, blank_d, frame_start_d, move_d;
  logic [9:0] hcount_d, vcount_d;

  vga_sync_gen #(
    .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .PIX_DIV (D), .MOVE_FRAMES (MF)
  ) dut (
    .clk (clk), .rst (rst), .move_en (move_en),
    .pixpulse (pixpulse), .hcount (hcount), .vcount (vcount),
    .hsync (hsync), .vsync (vsync), .blank (blank),
    .frame_start (frame_start), .move (move)
  );

  vga_sync_gen dut_d (
    .clk (clk), .rst (rst), .move_en (move_en_d),
    .pixpulse (pixpulse_d), .hcount (hcount_d), .vcount (vcount_d),
    .hsync (hsync_d), .vsync (vsync_d), .blank (blank_d),
    .frame_start (frame_start_d), .move (move_d)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  int unsigned cyc = 0;     // rising edges since reset release
  int n_en = 0;             // enabled strobe entries seen by the model
  logic [56:0] exp_q[$];    // {strobe cycle[31:0], expected outputs[24:0]}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h at cyc %0d", name, act, req, cyc);
  endtask

  // Reference: pixel n is the n-th raster position since reset release.
  function automatic logic [24:0] exp_vec(input int n, input logic mv);
    int h, v;
    logic hs, vs, bl, fs;
    h  = n % HT;
    v  = (n / HT) % VT;
    hs = !((h >= HV + HFP) && (h < HV + HFP + HS));
    vs = !((v >= VV + VFP) && (v < VV + VFP + VS));
    bl = (h >= HV) || (v >= VV);
    fs = (h == 0) && (v == 0) && (n > 0);
    return {h[9:0], v[9:0], hs, vs, bl, fs, mv};
  endfunction

  task automatic push_pixel(input int n);
    int h, v;
    logic mv;
    int unsigned pp;
    h  = n % HT;
    v  = (n / HT) % VT;
    mv = 1'b0;
    if (h == 0 && v == VV) begin
`ifdef VGA_MOVE_DIV_EN
      mv = move_en && ((n_en % MF) == 0);
      if (move_en) n_en++;
`else
      mv = move_en;
`endif
    end
    pp = n * D + D - 1;
    exp_q.push_back({pp, exp_vec(n, mv)});
  endtask

  // Model: a new pixel is entered every D rising edges after release.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        cyc++;
        if ((cyc % D) == 0) push_pixel(int'(cyc / D));
      end
    end
  end

  // Monitor: outputs must match the current pixel at every falling edge;
  // the strobe must appear exactly in that pixel's last clock.
  initial begin
    logic [56:0] e;
    forever begin
      @(negedge clk);
      if (rst && exp_q.size() > 0) begin
        e = exp_q[0];
        check("raster", {hcount, vcount, hsync, vsync, blank, frame_start, move}, e[24:0]);
        check("pixpulse", pixpulse, (cyc == e[56:25]));
        if (cyc >= e[56:25]) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    check({tag, "_small"}, {pixpulse, hcount, vcount, hsync, vsync, blank, frame_start, move},
          {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    check({tag, "_default"}, {pixpulse_d, hcount_d, vcount_d, hsync_d, vsync_d, blank_d, frame_start_d, move_d},
          {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    exp_q.delete();
    cyc  = 0;
    n_en = 0;
    push_pixel(0);
    rst = 1'b1;
  endtask

  // mode 0: move_en low, 1: high, 2: random every clock
  task automatic drive_frames(input int modes[]);
    foreach (modes[f]) begin
      for (int c = 0; c < FRAME_CLKS; c++) begin
        @(negedge clk);
        #1;
        case (modes[f])
          0:       move_en = 1'b0;
          1:       move_en = 1'b1;
          default: move_en = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  // Default 640x480 timing, first 3300 clocks: line wrap and hsync window.
  task automatic check_default();
    int npix;
    npix = 0;
    for (int c = 0; c < 3300; c++) begin
      @(negedge clk);
      if (pixpulse_d) begin
        int h;
        h = npix % 800;
        check("def_strobe_time", cyc, npix * 4 + 3);
        check("def_raster", {hcount_d, vcount_d, hsync_d, vsync_d, blank_d, frame_start_d, move_d},
              {h[9:0], 10'(npix / 800), !(h >= 656 && h <= 751), 1'b1, (h >= 640), 1'b0, 1'b0});
        npix++;
      end
    end
    check("def_strobe_count", npix, 825);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int modes1[];
    int modes2[];
    bit found;
    modes1 = '{1, 1, 1, 0, 1, 2, 1, 0, 2, 1};
    modes2 = '{1, 2, 1, 0, 1, 1};

    repeat (3) @(negedge clk);
    check_reset("reset_init");
    move_en = 1'b1;
    release_reset();
    fork
      drive_frames(modes1);
      check_default();
    join

    // Mid-frame asynchronous reset.
    found = 1'b0;
    for (int c = 0; c < 2 * FRAME_CLKS && !found; c++) begin
      @(negedge clk);
      if (hcount == 10'd10 && vcount == 10'd3) found = 1'b1;
    end
    check("midframe_reached", found, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_reset("reset_async");
    exp_q.delete();
    repeat (4) @(negedge clk);
    check_reset("reset_held");
    release_reset();
    drive_frames(modes2);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
